// File: rtl/elevator_call_panel.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_call_panel
//  Purpose  : Button-side front end for the elevator controller. Raw car and
//             hall buttons are synchronised and debounced. Each press becomes a
//             one-cycle request pulse. A lamp stays lit per call until the
//             controller serves it. Lit, unserved calls are re-pulsed
//             periodically so that a dropped request is recovered.
//  Ports    : CLK        - system clock, rising edge
//             RST_N      - asynchronous active-low reset
//             BTN[6:0]   - raw buttons {D3,D2,U2,U1,F3,F2,F1}, async
//             Open       - door-open status from the controller
//             Floor[1:0] - current floor 1..3 (0 = invalid)
//             Direction  - 00 idle, 01 up, 10 down, 11 idle
//             F1..D3     - registered one-cycle request pulses
//             LAMP[6:0]  - registered call lamps, same order as BTN
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_call_panel #(
    parameter int DEB_CYC   = 4,   // stable samples needed to flip a button (1..15)
    parameter int RETRY_CYC = 32   // re-pulse period for lit lamps, 0 = off
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] BTN,
    input  logic       Open,
    input  logic [1:0] Floor,
    input  logic [1:0] Direction,
    output logic       F1,
    output logic       F2,
    output logic       F3,
    output logic       U1,
    output logic       U2,
    output logic       D2,
    output logic       D3,
    output logic [6:0] LAMP
);

    localparam logic [3:0] c_DEB_LAST = 4'(DEB_CYC - 1);

    logic [6:0]      r_sync1;
    logic [6:0]      r_sync2;
    logic [6:0]      r_deb;
    logic [6:0]      r_deb_d;
    logic [6:0][3:0] r_cnt;
    logic [6:0]      r_req;
    logic [6:0]      r_lamp;

    logic [6:0]      w_press;
    logic [6:0]      w_match;
    logic            w_tick;
    logic            w_valid;
    logic            w_dir_up;
    logic            w_dir_dn;

    // A press is the rising edge of the debounced level; release is silent.
    assign w_press = r_deb & ~r_deb_d;

    // Service match: door open at a valid floor, hall calls also need the
    // travel direction to agree (idle serves either hall direction).
    assign w_valid  = Open && (Floor != 2'd0);
    assign w_dir_up = (Direction == 2'b01);
    assign w_dir_dn = (Direction == 2'b10);

    assign w_match[0] = w_valid && (Floor == 2'd1);
    assign w_match[1] = w_valid && (Floor == 2'd2);
    assign w_match[2] = w_valid && (Floor == 2'd3);
    assign w_match[3] = w_valid && (Floor == 2'd1);
    assign w_match[4] = w_valid && (Floor == 2'd2) && !w_dir_dn;
    assign w_match[5] = w_valid && (Floor == 2'd2) && !w_dir_up;
    assign w_match[6] = w_valid && (Floor == 2'd3);

    // ------------------------------------------------------------------
    // Retry timer: free-running 0..RETRY_CYC-1, tick on the last count.
    // ------------------------------------------------------------------
    generate
        if (RETRY_CYC > 0) begin : g_retry
            localparam int                 c_TIMER_W  = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
            localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(RETRY_CYC - 1);

            logic [c_TIMER_W-1:0] r_timer;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_timer <= '0;
                end else if (r_timer == c_TIMER_LAST) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + c_TIMER_W'(1);
                end
            end

            assign w_tick = (r_timer == c_TIMER_LAST);
        end else begin : g_no_retry
            assign w_tick = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Synchroniser, debounce, lamps and request pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            r_cnt   <= '0;
            r_req   <= '0;
            r_lamp  <= '0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;

            for (int b = 0; b < 7; b++) begin
                if (r_sync2[b] != r_deb[b]) begin
                    // Reaching DEB_CYC disagreeing samples flips the state.
                    if (r_cnt[b] == c_DEB_LAST) begin
                        r_deb[b] <= ~r_deb[b];
                        r_cnt[b] <= 4'd0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + 4'd1;
                    end
                end else begin
                    r_cnt[b] <= 4'd0;
                end
            end

            // Press and retry merge into a single pulse; a served call is
            // not retried in the cycle it is being served.
            r_req  <= w_press | ({7{w_tick}} & r_lamp & ~w_match);
            // Service clear wins over a simultaneous press (door reopen).
            r_lamp <= (r_lamp | w_press) & ~w_match;
        end
    end

    assign F1   = r_req[0];
    assign F2   = r_req[1];
    assign F3   = r_req[2];
    assign U1   = r_req[3];
    assign U2   = r_req[4];
    assign D2   = r_req[5];
    assign D3   = r_req[6];
    assign LAMP = r_lamp;

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_panel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_call_panel
//  Purpose  : Self-checking bench for elevator_call_panel. Two instances share
//             stimulus: one with default retry, one with retry disabled. A
//             behavioural model tracks expected pulses and lamps each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_call_panel;

    localparam int DEB   = 4;
    localparam int RETRY = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] btn;
    logic       open;
    logic [1:0] floor;
    logic [1:0] dir;

    logic a_f1, a_f2, a_f3, a_u1, a_u2, a_d2, a_d3;
    logic b_f1, b_f2, b_f3, b_u1, b_u2, b_d2, b_d3;
    logic [6:0] a_lamp, b_lamp;
    logic [6:0] a_req, b_req;

    assign a_req = {a_d3, a_d2, a_u2, a_u1, a_f3, a_f2, a_f1};
    assign b_req = {b_d3, b_d2, b_u2, b_u1, b_f3, b_f2, b_f1};

    always #5 clk = ~clk;

    elevator_call_panel #(.DEB_CYC(DEB), .RETRY_CYC(RETRY)) u_dut (
        .CLK(clk), .RST_N(rst_n), .BTN(btn), .Open(open), .Floor(floor),
        .Direction(dir), .F1(a_f1), .F2(a_f2), .F3(a_f3), .U1(a_u1),
        .U2(a_u2), .D2(a_d2), .D3(a_d3), .LAMP(a_lamp)
    );

    elevator_call_panel #(.DEB_CYC(DEB), .RETRY_CYC(0)) u_dut_noretry (
        .CLK(clk), .RST_N(rst_n), .BTN(btn), .Open(open), .Floor(floor),
        .Direction(dir), .F1(b_f1), .F2(b_f2), .F3(b_f3), .U1(b_u1),
        .U2(b_u2), .D2(b_d2), .D3(b_d3), .LAMP(b_lamp)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int unsigned m_cyc;
    bit [6:0]    m_s1, m_s2, m_deb, m_debp, m_lamp, m_req_a, m_req_b;
    int          m_run [7];

    function automatic bit served(int b, bit o, bit [1:0] f, bit [1:0] d);
        if (!o || f == 2'd0) return 1'b0;
        case (b)
            0: return f == 2'd1;
            1: return f == 2'd2;
            2: return f == 2'd3;
            3: return f == 2'd1;
            4: return f == 2'd2 && (d != 2'b10);
            5: return f == 2'd2 && (d != 2'b01);
            default: return f == 2'd3;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_debp = '0;
            m_lamp = '0; m_req_a = '0; m_req_b = '0;
            for (int b = 0; b < 7; b++) m_run[b] = 0;
        end else begin
            bit tick;
            tick = (m_cyc % RETRY) == RETRY - 1;
            for (int b = 0; b < 7; b++) begin
                bit pressed, srv;
                pressed = m_deb[b] && !m_debp[b];
                srv     = served(b, open, floor, dir);
                m_req_b[b] = pressed;
                m_req_a[b] = pressed || (tick && m_lamp[b] && !srv);
                if (srv)          m_lamp[b] = 1'b0;
                else if (pressed) m_lamp[b] = 1'b1;
            end
            m_debp = m_deb;
            for (int b = 0; b < 7; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_deb[b] = ~m_deb[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
            m_cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_assert = 0;
    int n_fail   = 0;
    int pca [7];
    int pcb [7];

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req_a",  a_req,  m_req_a);
        chk("lamp_a", a_lamp, m_lamp);
        chk("req_b",  b_req,  m_req_b);
        chk("lamp_b", b_lamp, m_lamp);
    endtask

    task automatic clr_pc();
        for (int b = 0; b < 7; b++) begin
            pca[b] = 0;
            pcb[b] = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
            for (int b = 0; b < 7; b++) begin
                if (a_req[b] === 1'b1) pca[b]++;
                if (b_req[b] === 1'b1) pcb[b]++;
            end
        end
    endtask

    task automatic do_reset();
        btn   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int tot;
        rst_n = 1'b0;
        btn   = 7'h7F;
        open  = 1'b0;
        floor = 2'd0;
        dir   = 2'b00;
        clr_pc();

        // Reset hold with every button pressed.
        repeat (4) begin
            @(negedge clk);
            chk("rst_req",  a_req,  7'h00);
            chk("rst_lamp", a_lamp, 7'h00);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run(1);
            chk("rst_latency", a_req, 7'h00);
        end
        run(1);
        chk("rst_all_pulse", a_req,  7'h7F);
        chk("rst_all_lamp",  a_lamp, 7'h7F);
        run(1);
        chk("rst_held_nopulse", a_req, 7'h00);

        // Glitch rejection, then a real press held.
        do_reset();
        clr_pc();
        btn = 7'h04;
        run(3);
        btn = 7'h00;
        run(12);
        chk("glitch_cnt",  7'(pca[2]), 7'd0);
        chk("glitch_lamp", a_lamp & 7'h04, 7'h00);
        clr_pc();
        btn = 7'h04;
        run(14);
        chk("press_cnt",  7'(pca[2]), 7'd1);
        chk("press_lamp", a_lamp & 7'h04, 7'h04);
        btn = 7'h00;

        // Service clear of U2 then D2 at floor 2.
        do_reset();
        btn = 7'h30;
        run(8);
        btn = 7'h00;
        run(4);
        chk("svc_lit", a_lamp, 7'h30);
        open = 1'b1; floor = 2'd2; dir = 2'b01;
        run(1);
        chk("svc_up", a_lamp & 7'h30, 7'h20);
        dir = 2'b10;
        run(1);
        chk("svc_dn", a_lamp & 7'h30, 7'h00);

        // Door reopen: press while served gives a pulse but no lamp.
        floor = 2'd1; dir = 2'b00;
        clr_pc();
        btn = 7'h08;
        run(10);
        btn = 7'h00;
        run(2);
        chk("reopen_cnt",  7'(pca[3]), 7'd1);
        chk("reopen_lamp", a_lamp & 7'h08, 7'h00);
        open = 1'b0; floor = 2'd0;

        // Retry: F2 lit, door closed for 100 cycles.
        do_reset();
        clr_pc();
        btn = 7'h02;
        run(8);
        btn = 7'h00;
        run(92);
        chk("retry_cnt",   7'(pca[1]), 7'd4);
        chk("noretry_cnt", 7'(pcb[1]), 7'd1);

        // Asynchronous reset between edges with lamps lit.
        do_reset();
        btn = 7'h15;
        run(8);
        btn = 7'h00;
        run(3);
        chk("pre_rst_lamp", a_lamp, 7'h15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_lamp_a", a_lamp, 7'h00);
        chk("async_lamp_b", b_lamp, 7'h00);
        chk("async_req",    a_req,  7'h00);
        run(2);
        rst_n = 1'b1;
        clr_pc();
        run(40);
        tot = 0;
        for (int b = 0; b < 7; b++) tot += pca[b] + pcb[b];
        chk("post_rst_pulses", 7'(tot), 7'd0);
        chk("post_rst_lamp",   a_lamp, 7'h00);

        // Randomised traffic against the model.
        do_reset();
        repeat (150) begin
            btn   = 7'($urandom);
            open  = 1'($urandom_range(0, 1));
            floor = 2'($urandom_range(0, 3));
            dir   = 2'($urandom_range(0, 3));
            run($urandom_range(1, 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Button-side front end for the ELEVATOR controller. It drives the controller's request inputs and consumes its Open/Floor/Direction outputs.
- Takes raw mechanical car and hall button levels, synchronises and debounces them, then emits one-cycle request pulses on F1/F2/F3/U1/U2/D2/D3.
- Holds a call lamp per button until the controller serves that call (door Open at the matching floor and direction).
- Re-issues pulses periodically for lit, unserved calls so that a dropped request is recovered.

Parameters:
- DEB_CYC, 4: consecutive stable synchronised samples required to change a debounced button state (1..15).
- RETRY_CYC, 32: period of the re-pulse timer for lit lamps; 0 disables retry.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- BTN  input  7  raw button levels, active-high, asynchronous. Bit order: [0]F1 [1]F2 [2]F3 [3]U1 [4]U2 [5]D2 [6]D3.
- Open  input  1  door-open status from ELEVATOR.
- Floor  input  2  current floor from ELEVATOR: 1..3; 0 means invalid.
- Direction  input  2  from ELEVATOR: 00 idle, 01 up, 10 down, 11 treated as idle.
- F1, F2, F3, U1, U2, D2, D3  output  1 each  registered one-cycle request pulses to ELEVATOR.
- LAMP  output  7  registered call lamps, same bit order as BTN.

Behaviour:
- Reset: asynchronous, active-low. All request outputs = 0, LAMP = 0, synchronisers = 0, debounced states = 0, debounce counters = 0, retry timer = 0. Reset mid-debounce or with lamps lit drops everything; no pulse is emitted on release.
- Sync: each BTN bit passes through a 2-flop synchroniser.
- Debounce, per bit:
  - The counter increments while the synchronised sample differs from the debounced state and clears when they match.
  - When the counter reaches DEB_CYC, the debounced state toggles and the counter clears.
  - Glitches shorter than DEB_CYC samples are ignored.
- Press event: rising edge of a debounced state, one per press. Holding a button produces no further presses; release is silent.
- Latency: BTN high and stable before edge N gives the request pulse high during the cycle after edge N+DEB_CYC+2, i.e. DEB_CYC+3 edges. With default DEB_CYC=4 that is 7 edges.
- Service match for bit b (evaluated combinationally each cycle):
  - Requires Open=1 and Floor valid.
  - F1/F2/F3: Floor equals the button floor.
  - U1: Floor=1, any Direction.
  - D3: Floor=3, any Direction.
  - U2: Floor=2 and Direction is up or idle.
  - D2: Floor=2 and Direction is down or idle.
- Lamp update, per bit, each cycle, in priority order:
  1. Service match: lamp clears.
  2. Press: lamp sets.
  3. Otherwise: lamp holds.
- A press during a matching service gets a pulse (door reopen) but the lamp stays 0.
- Pulse generation: the request output is 1 for exactly one cycle on a press. It also pulses on a retry tick if the lamp is lit and no match occurs that cycle.
- Retry timer:
  - A single free-running counter 0..RETRY_CYC-1, starting after reset.
  - The tick occurs in the cycle the counter equals RETRY_CYC-1.
  - On a tick, every lit lamp pulses simultaneously.
  - A press and a tick in the same cycle give one pulse, not two.
- Simultaneous presses: all pulse in the same cycle; no arbitration. ELEVATOR resolves ordering.
- Floor=0 or Open=0: no lamp clears.

Test Plan:
- Reset hold: RST_N low for 4 cycles with BTN=7'h7F -> all outputs 0 throughout; after release with BTN held, all seven pulses appear together 7 edges later, LAMP=7'h7F.
- Glitch reject: BTN[2] high for 3 cycles, then low -> no F3 pulse, LAMP[2]=0. High for 8 cycles -> exactly one F3 pulse, LAMP[2]=1, no further pulse while held before the first retry tick.
- Service clear: LAMP U2 and D2 lit; drive Open=1, Floor=2, Direction=01 -> LAMP[4] clears next cycle, LAMP[5] stays 1. Then Direction=10 -> LAMP[5] clears.
- Reopen: Open=1, Floor=1, press BTN[3] -> one U1 pulse, LAMP[3] stays 0.
- Retry: F2 lit, Open held 0, RETRY_CYC=32 -> F2 re-pulses once every 32 cycles, aligned with the timer tick. RETRY_CYC=0 -> no re-pulse.
- Mid-operation reset: lamps 7'h15 lit, assert RST_N low asynchronously between edges -> LAMP=0 immediately, no pulses after release.
